// File: rtl/wb_regfile_pkg.sv
// wb_regfile_pkg: shared pipeline constants and register-index type
package wb_regfile_pkg;
  localparam int DATA_W = 32;
  localparam int NREG_W = 5;
  localparam int PEND_W = 2;
  typedef logic [NREG_W-1:0] reg_idx_t;
  localparam reg_idx_t REG_ZERO = '0;
endpackage

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: per-register pending-write counters, busy/full flags and sticky errors
module wb_scoreboard
  import wb_regfile_pkg::*;
#(
  parameter int NREG_W = wb_regfile_pkg::NREG_W,
  parameter int PEND_W = wb_regfile_pkg::PEND_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iss_valid,
  input  logic [NREG_W-1:0] iss_rd,
  input  logic              rel_valid,
  input  logic [NREG_W-1:0] rel_rd,
  input  logic [NREG_W-1:0] rs1_addr,
  input  logic [NREG_W-1:0] rs2_addr,
  output logic              iss_full,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              err_ovf,
  output logic              err_unf
);
  localparam int NREG = 2**NREG_W;
  localparam logic [PEND_W-1:0] MAX = '1;
  logic [PEND_W-1:0] cnt_q [NREG];
  logic [PEND_W-1:0] cnt_d [NREG];
  logic [NREG-1:0] inc, dec;
  logic err_ovf_q, err_ovf_d, err_unf_q, err_unf_d;
  logic rel_hit1, rel_hit2;
  always_comb begin
    cnt_d = cnt_q;
    inc = '0;
    dec = '0;
    for (int r = 1; r < NREG; r++) begin
      dec[r] = rel_valid && rel_rd == NREG_W'(r) && cnt_q[r] != '0;
      // a release at max frees the slot this issue takes, so both apply
      inc[r] = iss_valid && iss_rd == NREG_W'(r) && (cnt_q[r] != MAX || dec[r]);
      cnt_d[r] = (inc[r] && !dec[r]) ? cnt_q[r] + 1'b1 :
                 (dec[r] && !inc[r]) ? cnt_q[r] - 1'b1 : cnt_q[r];
    end
    err_ovf_d = err_ovf_q | (iss_valid && iss_rd != '0 && cnt_q[iss_rd] == MAX &&
                             !(rel_valid && rel_rd == iss_rd));
    err_unf_d = err_unf_q | (rel_valid && rel_rd != '0 && cnt_q[rel_rd] == '0);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_ovf_q <= err_ovf_d;
      err_unf_q <= err_unf_d;
    end
  end
  assign rel_hit1 = rel_valid && rel_rd == rs1_addr && cnt_q[rs1_addr] != '0;
  assign rel_hit2 = rel_valid && rel_rd == rs2_addr && cnt_q[rs2_addr] != '0;
  assign rs1_busy = rs1_addr != '0 && (cnt_q[rs1_addr] - PEND_W'(rel_hit1)) != '0;
  assign rs2_busy = rs2_addr != '0 && (cnt_q[rs2_addr] - PEND_W'(rel_hit2)) != '0;
  assign iss_full = iss_rd != '0 && cnt_q[iss_rd] == MAX;
  assign err_ovf  = err_ovf_q;
  assign err_unf  = err_unf_q;
endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: write-back register file with write-first bypass and pending-write scoreboard
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = wb_regfile_pkg::DATA_W,
  parameter int NREG_W = wb_regfile_pkg::NREG_W,
  parameter int PEND_W = wb_regfile_pkg::PEND_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_we,
  input  logic [NREG_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              rel_valid,
  input  logic [NREG_W-1:0] rel_rd,
  input  logic              iss_valid,
  input  logic [NREG_W-1:0] iss_rd,
  output logic              iss_full,
  input  logic [NREG_W-1:0] rs1_addr,
  input  logic [NREG_W-1:0] rs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              err_ovf,
  output logic              err_unf
);
  localparam int NREG = 2**NREG_W;
  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic wr_en;
  assign wr_en = wb_we && wb_rd != NREG_W'(REG_ZERO);
  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[wb_rd] = wb_data;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) for (int r = 0; r < NREG; r++) regs_q[r] <= '0;
    else regs_q <= regs_d;
  end
  assign rs1_data = rs1_addr == NREG_W'(REG_ZERO) ? '0 :
                    (wr_en && wb_rd == rs1_addr) ? wb_data : regs_q[rs1_addr];
  assign rs2_data = rs2_addr == NREG_W'(REG_ZERO) ? '0 :
                    (wr_en && wb_rd == rs2_addr) ? wb_data : regs_q[rs2_addr];
  wb_scoreboard #(.NREG_W(NREG_W), .PEND_W(PEND_W)) u_sb (
    .clk(clk), .rst_n(rst_n),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .rel_valid(rel_valid), .rel_rd(rel_rd),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .iss_full(iss_full), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .err_ovf(err_ovf), .err_unf(err_unf)
  );
endmodule
